// File: rtl/ssm_funnel_shifter.sv
// SSM funnel shifter: MSB-first bit window over a substream word FIFO.
// Optional retired-bit counter via `SSM_FUNNEL_BITCNT_EN.
`timescale 1ns/1ps
module ssm_funnel_shifter #(
  parameter int DATA_W = 128,
  parameter int SE_MAX = 128,
  parameter int BUF_W  = DATA_W + SE_MAX,
  parameter int CNT_W  = $clog2(BUF_W + 1),
  parameter int CB_W   = $clog2(SE_MAX + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              win_valid,
  output logic [SE_MAX-1:0] win_data,
  input  logic              consume_en,
  input  logic [CB_W-1:0]   consume_bits,
  output logic [CNT_W-1:0]  fullness,
`ifdef SSM_FUNNEL_BITCNT_EN
  output logic [31:0]       bits_consumed,
`endif
  output logic              err
);

  localparam logic [CB_W-1:0]  SE_MAX_CB = CB_W'(SE_MAX);
  localparam logic [CNT_W-1:0] SE_MAX_F  = CNT_W'(SE_MAX);
  localparam logic [CNT_W-1:0] DATA_W_F  = CNT_W'(DATA_W);
  localparam logic [CNT_W:0]   DATA_W_E  = (CNT_W+1)'(DATA_W);
  localparam logic [CNT_W:0]   BUF_W_E   = (CNT_W+1)'(BUF_W);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] f_q, f_d;
  logic             err_q, err_d;

  logic             cb_ok;
  logic             cacc;
  logic             bad;
  logic [CB_W-1:0]  c;
  logic [CNT_W-1:0] fp;
  logic             wacc;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] ins;

  assign win_valid = (f_q >= SE_MAX_F);
  assign win_data  = buf_q[BUF_W-1 -: SE_MAX];
  assign fullness  = f_q;
  assign err       = err_q;

  // Consume acceptance and the retained-bit count after retiring
  always_comb begin
    cb_ok = (consume_bits <= SE_MAX_CB);
    cacc  = consume_en & win_valid & cb_ok;
    bad   = consume_en & ~(win_valid & cb_ok);
    c     = cacc ? consume_bits : '0;
    fp    = f_q - CNT_W'(c);
  end

  // Room check uses the post-consume count so a same-cycle retire frees space
  always_comb begin
    in_ready = (({1'b0, fp} + DATA_W_E) <= BUF_W_E) & ~flush;
    wacc     = in_valid & in_ready;
  end

  // Shift out retired bits, then land the new word just below retained bits
  always_comb begin
    shifted = buf_q << c;
    ins     = {in_data, {(BUF_W-DATA_W){1'b0}}} >> fp;
    buf_d   = shifted;
    f_d     = fp;
    err_d   = err_q | bad;
    if (wacc) begin
      buf_d = shifted | ins;
      f_d   = fp + DATA_W_F;
    end
    if (flush) begin
      buf_d = '0;
      f_d   = '0;
      err_d = 1'b0;
    end
  end

  // Buffer, fullness and sticky error state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q <= '0;
      f_q   <= '0;
      err_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      f_q   <= f_d;
      err_q <= err_d;
    end
  end

`ifdef SSM_FUNNEL_BITCNT_EN
  logic [31:0] bc_q, bc_d;

  assign bits_consumed = bc_q;

  // Running total of retired bits, wraps modulo 2^32
  always_comb begin
    bc_d = bc_q + 32'(c);
    if (flush) bc_d = '0;
  end

  // Retired-bit counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bc_q <= '0;
    else       bc_q <= bc_d;
  end
`endif

endmodule
